// File: rtl/tag_arbiter_if.sv
// Tag readout channel: valid/ready handshake carrying source code and timestamp.
interface tag_arbiter_if #(
  parameter int CNT_W = 32
);
  logic             tag_valid;
  logic             tag_ready;
  logic [1:0]       tag_src;
  logic [CNT_W-1:0] tag_cnt;

  modport master (output tag_valid, tag_src, tag_cnt, input tag_ready);
  modport slave  (input tag_valid, tag_src, tag_cnt, output tag_ready);
endinterface

// File: rtl/tag_arbiter.sv
// Timestamps rising edges of two trigger sources against a PPS-aligned counter and
// issues them one at a time on a shared tag channel with round-robin and dead time.
module tag_arbiter #(
  parameter int CNT_W    = 32,
  parameter int DEAD_CYC = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pps,
  input  logic          trig_a,
  input  logic          trig_b,
  tag_arbiter_if.master tag,
  output logic          lost,
  output logic [7:0]    lost_cnt,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  state_t           state;
  logic [DW-1:0]    dead_ctr;
  logic             trig_a_d;
  logic             trig_b_d;
  logic             pps_d;
  logic [CNT_W-1:0] cnt;
  logic             pend_a;
  logic             pend_b;
  logic [CNT_W-1:0] ts_a;
  logic [CNT_W-1:0] ts_b;
  logic             rr_b_first;

  logic             edge_a;
  logic             edge_b;
  logic             pps_edge;
  logic             grant_a;
  logic             grant_b;
  logic             drop_a;
  logic             drop_b;
  logic [8:0]       lost_sum;

  assign edge_a   = trig_a & ~trig_a_d & en;
  assign edge_b   = trig_b & ~trig_b_d & en;
  assign pps_edge = pps & ~pps_d;

  // NOTE: every signal gets a default before the decision tree so no latch is inferred.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
      if (pend_a && pend_b) begin
        if (ts_a == ts_b) begin
          grant_a = 1'b1;
          grant_b = 1'b1;
        end else if (rr_b_first) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end else begin
        grant_a = pend_a;
        grant_b = pend_b;
      end
    end
  end

  // A slot being granted this cycle is free for a new edge, so that edge is not a loss.
  assign drop_a   = edge_a & pend_a & ~grant_a;
  assign drop_b   = edge_b & pend_b & ~grant_b;
  assign lost_sum = {1'b0, lost_cnt} + {8'd0, drop_a} + {8'd0, drop_b};

  assign busy = (state != IDLE) | pend_a | pend_b;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_a_d <= 1'b0;
      trig_b_d <= 1'b0;
      pps_d    <= 1'b0;
      cnt      <= '0;
    end else begin
      trig_a_d <= trig_a;
      trig_b_d <= trig_b;
      pps_d    <= pps;
      cnt      <= pps_edge ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
      ts_a     <= '0;
      ts_b     <= '0;
      lost     <= 1'b0;
      lost_cnt <= 8'd0;
    end else begin
      if (edge_a && !drop_a) begin
        pend_a <= 1'b1;
        ts_a   <= cnt;
      end else if (grant_a) begin
        pend_a <= 1'b0;
      end

      if (edge_b && !drop_b) begin
        pend_b <= 1'b1;
        ts_b   <= cnt;
      end else if (grant_b) begin
        pend_b <= 1'b0;
      end

      lost     <= drop_a | drop_b;
      lost_cnt <= lost_sum[8] ? 8'hFF : lost_sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dead_ctr      <= '0;
      rr_b_first    <= 1'b0;
      tag.tag_valid <= 1'b0;
      tag.tag_src   <= 2'b00;
      tag.tag_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            state         <= OUT;
            tag.tag_valid <= 1'b1;
            tag.tag_src   <= {grant_b, grant_a};
            tag.tag_cnt   <= grant_a ? ts_a : ts_b;
            // Coincidence grants leave the round-robin pointer where it was.
            if (grant_a ^ grant_b) begin
              rr_b_first <= grant_a;
            end
          end
        end
        OUT: begin
          if (tag.tag_ready) begin
            tag.tag_valid <= 1'b0;
            if (DEAD_CYC == 0) begin
              state <= IDLE;
            end else begin
              state    <= DEAD;
              dead_ctr <= DW'(DEAD_CYC - 1);
            end
          end
        end
        DEAD: begin
          if (dead_ctr == '0) begin
            state <= IDLE;
          end else begin
            dead_ctr <= dead_ctr - DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_arbiter.sv
// Self-checking bench for tag_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_tag_arbiter;
  localparam int CNT_W    = 32;
  localparam int DEAD_CYC = 4;

  typedef logic [CNT_W+1:0] hs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pps;
  logic       trig_a;
  logic       trig_b;
  logic       lost;
  logic [7:0] lost_cnt;
  logic       busy;

  logic       rst2;
  logic       trig_a2;
  logic       trig_b2;
  logic       lost2;
  logic [7:0] lost_cnt2;
  logic       busy2;

  tag_arbiter_if #(.CNT_W(CNT_W)) bus ();
  tag_arbiter_if #(.CNT_W(4))     bus2 ();

  tag_arbiter #(.CNT_W(CNT_W), .DEAD_CYC(DEAD_CYC)) dut (
    .clk(clk), .rst(rst), .en(en), .pps(pps), .trig_a(trig_a), .trig_b(trig_b),
    .tag(bus), .lost(lost), .lost_cnt(lost_cnt), .busy(busy)
  );

  // Narrow-counter, zero-dead-time instance for counter wrap.
  tag_arbiter #(.CNT_W(4), .DEAD_CYC(0)) dut2 (
    .clk(clk), .rst(rst2), .en(1'b1), .pps(1'b0), .trig_a(trig_a2), .trig_b(trig_b2),
    .tag(bus2), .lost(lost2), .lost_cnt(lost_cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: slots, one tag in flight, and the first cycle the channel may grant again.
  int               n;
  int               grant_ok;
  int               m_last;
  int               m_lost_cnt;
  int               win;
  bit               m_pend [2];
  logic [CNT_W-1:0] m_ts   [2];
  bit               m_valid;
  logic [1:0]       m_src;
  logic [CNT_W-1:0] m_tcnt;
  logic [CNT_W-1:0] m_cnt;
  bit               m_lost;
  bit               p_a, p_b, p_pps;
  bit [1:0]         e, g;
  bit               pe;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; grant_ok = 0; m_last = 1; m_lost_cnt = 0;
      m_pend[0] = 0; m_pend[1] = 0; m_ts[0] = '0; m_ts[1] = '0;
      m_valid = 0; m_src = 2'b00; m_tcnt = '0; m_cnt = '0; m_lost = 0;
      p_a = 0; p_b = 0; p_pps = 0;
    end else begin
      n++;
      e[0] = trig_a && !p_a && en;
      e[1] = trig_b && !p_b && en;
      pe   = pps && !p_pps;
      g    = 2'b00;
      if (!m_valid && n >= grant_ok && (m_pend[0] || m_pend[1])) begin
        if (m_pend[0] && m_pend[1] && m_ts[0] == m_ts[1]) begin
          g = 2'b11;
        end else begin
          win = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[0] ? 0 : 1);
          g[win] = 1'b1;
          m_last = win;
        end
        m_valid = 1;
        m_src   = g;
        m_tcnt  = g[0] ? m_ts[0] : m_ts[1];
      end else if (m_valid && bus.tag_ready) begin
        m_valid  = 0;
        grant_ok = n + DEAD_CYC + 1;
      end
      m_lost = 0;
      for (int s = 0; s < 2; s++) begin
        if (g[s]) m_pend[s] = 0;
        if (e[s]) begin
          if (m_pend[s]) begin
            m_lost     = 1;
            m_lost_cnt = (m_lost_cnt >= 255) ? 255 : m_lost_cnt + 1;
          end else begin
            m_pend[s] = 1;
            m_ts[s]   = m_cnt;
          end
        end
      end
      m_cnt = pe ? '0 : m_cnt + 1;
      p_a = trig_a; p_b = trig_b; p_pps = pps;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("tag_valid", bus.tag_valid, m_valid);
      if (m_valid) begin
        check("tag_src", bus.tag_src, m_src);
        check("tag_cnt", bus.tag_cnt, m_tcnt);
      end
      check("lost", lost, m_lost);
      check("lost_cnt", lost_cnt, m_lost_cnt);
      check("busy", busy, m_pend[0] || m_pend[1] || m_valid || (n <= grant_ok - 2));
    end
  end

  hs_t        hs_q [$];
  logic [5:0] q2   [$];

  always @(negedge clk) begin
    if (!rst && bus.tag_valid && bus.tag_ready) hs_q.push_back({bus.tag_src, bus.tag_cnt});
    if (!rst2 && bus2.tag_valid && bus2.tag_ready) q2.push_back({bus2.tag_src, bus2.tag_cnt});
  end

  int         busy_n, valid_n, first_valid, lost_n, r;
  logic [1:0] cap_src;
  logic [CNT_W-1:0] cap_cnt;

  initial begin
    rst = 1'b0; rst2 = 1'b0;
    en = 1'b0; pps = 1'b0; trig_a = 1'b0; trig_b = 1'b0;
    trig_a2 = 1'b0; trig_b2 = 1'b0;
    bus.tag_ready = 1'b0; bus2.tag_ready = 1'b1;
    #1 rst = 1'b1; rst2 = 1'b1;
    #20;
    check("reset tag_valid", bus.tag_valid, 0);
    check("reset tag_src", bus.tag_src, 0);
    check("reset tag_cnt", bus.tag_cnt, 0);
    check("reset lost", lost, 0);
    check("reset lost_cnt", lost_cnt, 0);
    check("reset busy", busy, 0);
    en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Single A edge at cnt = 100 with ready already high.
    bus.tag_ready = 1'b1;
    tick(100);
    trig_a = 1'b1;
    busy_n = 0; valid_n = 0; first_valid = 0; cap_src = '0; cap_cnt = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) trig_a = 1'b0;
      busy_n  += int'(busy);
      valid_n += int'(bus.tag_valid);
      if (bus.tag_valid && first_valid == 0) begin
        first_valid = i; cap_src = bus.tag_src; cap_cnt = bus.tag_cnt;
      end
    end
    check("single latency", first_valid, 2);
    check("single valid cycles", valid_n, 1);
    check("single busy cycles", busy_n, 6);
    check("single src", cap_src, 2'b01);
    check("single cnt", cap_cnt, 100);

    // Coincidence at cnt = 500.
    hs_q.delete(); lost_n = 0;
    pps = 1'b1; tick(); pps = 1'b0;
    tick(500);
    trig_a = 1'b1; trig_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      trig_a = 1'b0; trig_b = 1'b0;
      lost_n += int'(lost);
    end
    check("coinc tag count", hs_q.size(), 1);
    check("coinc tag", hs_q[0], {2'b11, 32'd500});
    check("coinc lost pulses", lost_n, 0);

    // A at 10, B at 12, consumer stalled.
    hs_q.delete(); bus.tag_ready = 1'b0;
    pps = 1'b1; tick(); pps = 1'b0;
    tick(10);
    trig_a = 1'b1; tick(); trig_a = 1'b0; tick();
    trig_b = 1'b1; tick(); trig_b = 1'b0;
    tick(8); bus.tag_ready = 1'b1; tick(20);
    check("ab tag count", hs_q.size(), 2);
    check("ab first", hs_q[0], {2'b01, 32'd10});
    check("ab second", hs_q[1], {2'b10, 32'd12});
    check("ab lost_cnt", lost_cnt, 0);

    // Contention after A was the last single grant: B must win.
    hs_q.delete(); bus.tag_ready = 1'b0;
    pps = 1'b1; tick(); pps = 1'b0;
    trig_a = 1'b1; tick(); trig_a = 1'b0; tick();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    trig_b = 1'b1; tick(); trig_b = 1'b0;
    tick(5); bus.tag_ready = 1'b1; tick(30);
    check("rr tag count", hs_q.size(), 3);
    check("rr first", hs_q[0], {2'b01, 32'd0});
    check("rr second", hs_q[1], {2'b10, 32'd3});
    check("rr third", hs_q[2], {2'b01, 32'd2});

    // Losses and saturation.
    hs_q.delete(); bus.tag_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      trig_a = 1'b1; tick();
      if (i == 2) check("third edge lost", lost, 1);
      trig_a = 1'b0; tick();
    end
    check("lost pulse width", lost, 0);
    check("lost_cnt after 3", lost_cnt, 1);
    trig_b = 1'b1; tick(); trig_b = 1'b0; tick();
    trig_a = 1'b1; trig_b = 1'b1; tick();
    check("double drop pulse", lost, 1);
    trig_a = 1'b0; trig_b = 1'b0; tick();
    check("double drop pulse end", lost, 0);
    check("lost_cnt double", lost_cnt, 3);
    for (int i = 0; i < 300; i++) begin
      trig_a = 1'b1; tick(); trig_a = 1'b0; tick();
    end
    check("lost_cnt saturate", lost_cnt, 255);
    bus.tag_ready = 1'b1; tick(40);
    check("drain tag count", hs_q.size(), 3);
    check("drain idle", busy, 0);

    // PPS coincident with an edge, then a second edge five cycles later.
    hs_q.delete();
    pps = 1'b1; tick(); pps = 1'b0;
    tick(32'h1234);
    pps = 1'b1; trig_a = 1'b1; tick();
    pps = 1'b0; trig_a = 1'b0; tick(4);
    trig_a = 1'b1; tick(); trig_a = 1'b0; tick(30);
    check("pps tag count", hs_q.size(), 2);
    check("pps same cycle", hs_q[0], {2'b01, 32'h1234});
    check("pps after", hs_q[1], {2'b01, 32'd4});

    // Reset mid-handshake; B held high through release gives exactly one fresh tag.
    bus.tag_ready = 1'b0;
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    for (int i = 0; i < 10 && !bus.tag_valid; i++) tick();
    check("valid before reset", bus.tag_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("async reset tag_valid", bus.tag_valid, 0);
    check("async reset tag_src", bus.tag_src, 0);
    check("async reset tag_cnt", bus.tag_cnt, 0);
    check("async reset lost_cnt", lost_cnt, 0);
    check("async reset busy", busy, 0);
    trig_b = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    hs_q.delete(); bus.tag_ready = 1'b1;
    tick(20);
    trig_b = 1'b0;
    check("post reset tags", hs_q.size(), 1);
    check("post reset tag", hs_q[0], {2'b10, 32'd0});

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      r      = $urandom_range(0, 9);
      en     = ($urandom_range(0, 15) != 0);
      if (r < 3) trig_a = ~trig_a;
      else if (r < 6) trig_b = ~trig_b;
      else if (r == 6) begin
        trig_a = ~trig_a;
        trig_b = trig_a;
      end
      pps = ($urandom_range(0, 99) == 0);
      bus.tag_ready = (i < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end
    trig_a = 1'b0; trig_b = 1'b0; pps = 1'b0; bus.tag_ready = 1'b1; en = 1'b1;
    tick(40);

    // Counter wrap on the 4-bit, zero-dead-time instance.
    @(posedge clk); #1 rst2 = 1'b0;
    tick(15);
    trig_a2 = 1'b1; tick();
    trig_b2 = 1'b1; tick();
    trig_a2 = 1'b0; trig_b2 = 1'b0;
    tick(10);
    check("wrap tag count", q2.size(), 2);
    check("wrap first", q2[0], {2'b01, 4'd15});
    check("wrap second", q2[1], {2'b10, 4'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
